// File: rtl/rs_issue_scheduler.sv
// Centralized reservation station: dispatch into the lowest free slot, wake up on
// writeback tags, and offer the lowest-index ready entry to each functional unit.
package core_pkg;
    localparam int unsigned RS_ENTRIES = 32;
    localparam int unsigned NUM_FUS    = 4;
    localparam int unsigned NUM_PREGS  = 64;
    localparam int unsigned PREG_W     = $clog2(NUM_PREGS);
    localparam int unsigned FU_W       = $clog2(NUM_FUS);

    typedef struct packed {
        logic              instr_valid;
        logic [6:0]        opcode;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
        logic              src1_dp_en;
        logic              src2_dp_en;
        logic [FU_W-1:0]   ex_pipe_dst;
    } disp_packet_t;
endpackage

module rs_issue_scheduler #(
    parameter int unsigned RS_ENTRIES = core_pkg::RS_ENTRIES,
    parameter int unsigned NUM_FUS    = core_pkg::NUM_FUS,
    parameter int unsigned PREG_W     = core_pkg::PREG_W
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              flush,
    input  logic                                              disp_valid,
    input  core_pkg::disp_packet_t                            disp_pkt,
    input  logic                                              disp_src1_rdy,
    input  logic                                              disp_src2_rdy,
    output logic                                              disp_ready,
    input  logic [NUM_FUS-1:0]                                wb_valid,
    input  logic [NUM_FUS*PREG_W-1:0]                         wb_preg,
    output logic [NUM_FUS-1:0]                                issue_valid,
    input  logic [NUM_FUS-1:0]                                issue_ready,
    output logic [NUM_FUS*$bits(core_pkg::disp_packet_t)-1:0] issue_pkt,
    output logic [$clog2(RS_ENTRIES):0]                       occupancy
);
    localparam int unsigned IDX_W = $clog2(RS_ENTRIES);
    localparam int unsigned OCC_W = IDX_W + 1;
    localparam int unsigned PKT_W = $bits(core_pkg::disp_packet_t);
    localparam int unsigned FU_W  = core_pkg::FU_W;

    logic [RS_ENTRIES-1:0]  valid, rdy1, rdy2;
    core_pkg::disp_packet_t pkt [RS_ENTRIES];
    logic [OCC_W-1:0]       occ;

    logic [RS_ENTRIES-1:0]  hit1, hit2, clr;
    logic                   dhit1, dhit2, accept, free_found;
    logic [IDX_W-1:0]       free_idx;
    logic [IDX_W-1:0]       sel_idx [NUM_FUS];
    logic [NUM_FUS-1:0]     sel_any, fire;
    logic [OCC_W-1:0]       num_issue;

    function automatic logic tag_hit(input logic [PREG_W-1:0]         tag,
                                     input logic [NUM_FUS-1:0]        wv,
                                     input logic [NUM_FUS*PREG_W-1:0] wp);
        tag_hit = 1'b0;
        for (int unsigned f = 0; f < NUM_FUS; f++)
            if (wv[f] && (wp[f*PREG_W +: PREG_W] == tag)) tag_hit = 1'b1;
    endfunction

    // Backpressure looks only at registered occupancy; slots freed this cycle wait a cycle.
    assign disp_ready = rst_n && (occ < OCC_W'(RS_ENTRIES));
    assign accept     = disp_valid && disp_ready && disp_pkt.instr_valid && !flush;
    assign occupancy  = occ;

    always_comb begin
        hit1  = '0;
        hit2  = '0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            hit1[i] = tag_hit(pkt[i].src1_preg, wb_valid, wb_preg);
            hit2[i] = tag_hit(pkt[i].src2_preg, wb_valid, wb_preg);
        end
        dhit1 = tag_hit(disp_pkt.src1_preg, wb_valid, wb_preg);
        dhit2 = tag_hit(disp_pkt.src2_preg, wb_valid, wb_preg);
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_any     = '0;
        fire        = '0;
        clr         = '0;
        num_issue   = '0;
        issue_valid = '0;
        issue_pkt   = '0;
        for (int unsigned f = 0; f < NUM_FUS; f++) begin
            sel_idx[f] = '0;
            for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
                if (valid[i] && rdy1[i] && rdy2[i] && (pkt[i].ex_pipe_dst == FU_W'(f))
                    && !sel_any[f]) begin
                    sel_any[f] = 1'b1;
                    sel_idx[f] = IDX_W'(i);
                end
            end
            issue_valid[f]                = rst_n && sel_any[f];
            issue_pkt[f*PKT_W +: PKT_W]   = pkt[sel_idx[f]];
            fire[f]                       = issue_valid[f] && issue_ready[f];
            if (fire[f]) begin
                clr[sel_idx[f]] = 1'b1;
                num_issue       = num_issue + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid <= '0;
            occ   <= '0;
        end else begin
            valid <= valid & ~clr;
            if (accept) valid[free_idx] <= 1'b1;
            occ <= occ + OCC_W'(accept) - num_issue;
        end
    end

    // Payload and ready bits need no reset; they are qualified by valid everywhere.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
            if (hit1[i]) rdy1[i] <= 1'b1;
            if (hit2[i]) rdy2[i] <= 1'b1;
        end
        if (accept) begin
            pkt[free_idx]  <= disp_pkt;
            rdy1[free_idx] <= !disp_pkt.src1_dp_en || disp_src1_rdy || dhit1;
            rdy2[free_idx] <= !disp_pkt.src2_dp_en || disp_src2_rdy || dhit2;
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios plus randomized
// traffic compared against a slot-array reference model.
module tb_rs_issue_scheduler;
    import core_pkg::*;

    localparam int RSE   = 32;
    localparam int NF    = 4;
    localparam int PW    = 6;
    localparam int PKT_W = $bits(disp_packet_t);

    logic               clk = 1'b0;
    logic               rst_n, flush, disp_valid, disp_src1_rdy, disp_src2_rdy, disp_ready;
    disp_packet_t       disp_pkt;
    logic [NF-1:0]      wb_valid, issue_valid, issue_ready;
    logic [NF*PW-1:0]   wb_preg;
    logic [NF*PKT_W-1:0] issue_pkt;
    logic [5:0]         occupancy;

    int checks = 0;
    int errors = 0;

    bit           m_valid [RSE];
    disp_packet_t m_pkt   [RSE];
    bit           m_r1    [RSE];
    bit           m_r2    [RSE];

    rs_issue_scheduler #(.RS_ENTRIES(RSE), .NUM_FUS(NF), .PREG_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_pkt(disp_pkt),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_ready(disp_ready), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_pkt(issue_pkt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic bit wb_match(logic [PW-1:0] tag);
        for (int f = 0; f < NF; f++)
            if (wb_valid[f] && wb_preg[f*PW +: PW] == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < RSE; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic int m_sel(int f);
        for (int i = 0; i < RSE; i++)
            if (m_valid[i] && m_r1[i] && m_r2[i] && int'(m_pkt[i].ex_pipe_dst) == f) return i;
        return -1;
    endfunction

    function automatic disp_packet_t dut_pkt(int f);
        return issue_pkt[f*PKT_W +: PKT_W];
    endfunction

    function automatic disp_packet_t make_pkt(int dst, bit e1, int s1, bit e2, int s2, int pipe);
        disp_packet_t p;
        p.instr_valid = 1'b1;
        p.opcode      = 7'($urandom);
        p.dst_preg    = 6'(dst);
        p.src1_preg   = 6'(s1);
        p.src2_preg   = 6'(s2);
        p.src1_dp_en  = e1;
        p.src2_dp_en  = e2;
        p.ex_pipe_dst = 2'(pipe);
        return p;
    endfunction

    // Advance the reference model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int sel [NF];
        int slot;
        bit acc;
        if (!rst_n || flush) begin
            for (int i = 0; i < RSE; i++) m_valid[i] = 1'b0;
            return;
        end
        for (int f = 0; f < NF; f++) sel[f] = m_sel(f);
        slot = -1;
        for (int i = 0; i < RSE; i++) if (!m_valid[i]) begin slot = i; break; end
        acc = disp_valid && (m_count() < RSE) && disp_pkt.instr_valid;
        for (int i = 0; i < RSE; i++) begin
            if (wb_match(m_pkt[i].src1_preg)) m_r1[i] = 1'b1;
            if (wb_match(m_pkt[i].src2_preg)) m_r2[i] = 1'b1;
        end
        for (int f = 0; f < NF; f++)
            if (sel[f] >= 0 && issue_ready[f]) m_valid[sel[f]] = 1'b0;
        if (acc) begin
            m_valid[slot] = 1'b1;
            m_pkt[slot]   = disp_pkt;
            m_r1[slot]    = !disp_pkt.src1_dp_en || disp_src1_rdy || wb_match(disp_pkt.src1_preg);
            m_r2[slot]    = !disp_pkt.src2_dp_en || disp_src2_rdy || wb_match(disp_pkt.src2_preg);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
        wb_valid = '0; wb_preg = '0; issue_ready = '0;
        disp_pkt = make_pkt(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        tick(); tick();
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL reset_disp_ready: got %b expected 0", disp_ready); end
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0000", issue_valid); end
        rst_n = 1; #1;
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", disp_ready); end
    endtask

    task automatic test_wakeup();
        disp_pkt = make_pkt(5, 1, 3, 0, 0, 1); disp_valid = 1;
        tick(); disp_valid = 0;
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL wake_not_ready: got %b expected 0000", issue_valid); end
        checks++; if (occupancy !== 6'd1) begin errors++; $display("FAIL wake_occ1: got %0d expected 1", occupancy); end
        wb_valid = 4'b0100; wb_preg[2*PW +: PW] = 6'd3;
        tick(); wb_valid = '0; wb_preg = '0;
        checks++; if (issue_valid !== 4'b0010) begin errors++; $display("FAIL wake_issue_valid: got %b expected 0010", issue_valid); end
        checks++; if (dut_pkt(1).dst_preg !== 6'd5) begin errors++; $display("FAIL wake_dst: got %0d expected 5", dut_pkt(1).dst_preg); end
        issue_ready[1] = 1;
        tick(); issue_ready = '0;
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL wake_drain_occ: got %0d expected 0", occupancy); end
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL wake_drain_valid: got %b expected 0000", issue_valid); end
    endtask

    task automatic test_bypass();
        disp_pkt = make_pkt(8, 1, 7, 0, 0, 3); disp_valid = 1;
        wb_valid = 4'b0001; wb_preg[0 +: PW] = 6'd7;
        tick(); idle();
        checks++; if (issue_valid !== 4'b1000) begin errors++; $display("FAIL bypass_valid: got %b expected 1000", issue_valid); end
        checks++; if (dut_pkt(3).dst_preg !== 6'd8) begin errors++; $display("FAIL bypass_dst: got %0d expected 8", dut_pkt(3).dst_preg); end
        issue_ready[3] = 1;
        tick(); idle();
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL bypass_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < RSE; i++) begin
            disp_pkt = make_pkt(i, 1, 9, 0, 0, 0); disp_valid = 1;
            checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, disp_ready); end
            tick();
        end
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", disp_ready); end
        checks++; if (occupancy !== 6'd32) begin errors++; $display("FAIL full_occ: got %0d expected 32", occupancy); end
        disp_pkt = make_pkt(40, 0, 0, 0, 0, 0);
        tick(); idle();
        checks++; if (occupancy !== 6'd32) begin errors++; $display("FAIL overflow_occ: got %0d expected 32", occupancy); end
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL full_no_issue: got %b expected 0000", issue_valid); end
        wb_valid = 4'b0010; wb_preg[1*PW +: PW] = 6'd9;
        tick(); idle();
        issue_ready[0] = 1;
        for (int k = 0; k < RSE; k++) begin
            checks++;
            if (issue_valid[0] !== 1'b1 || dut_pkt(0).dst_preg !== 6'(k)) begin
                errors++;
                $display("FAIL drain_order_%0d: got valid=%b dst=%0d expected valid=1 dst=%0d",
                         k, issue_valid[0], dut_pkt(0).dst_preg, k);
            end
            tick();
        end
        idle();
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_parallel();
        for (int i = 0; i < NF; i++) begin
            disp_pkt = make_pkt(30 + i, 0, 0, 0, 0, i); disp_valid = 1;
            tick();
        end
        idle();
        checks++; if (occupancy !== 6'd4) begin errors++; $display("FAIL par_occ: got %0d expected 4", occupancy); end
        checks++; if (issue_valid !== 4'b1111) begin errors++; $display("FAIL par_valid: got %b expected 1111", issue_valid); end
        issue_ready = 4'b1111;
        tick(); idle();
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL par_drain_occ: got %0d expected 0", occupancy); end
    endtask

    task automatic test_hold();
        disp_valid = 1;
        disp_pkt = make_pkt(20, 0, 0, 0, 0, 2); tick();
        for (int i = 0; i < 3; i++) begin disp_pkt = make_pkt(21 + i, 1, 11, 0, 0, 0); tick(); end
        disp_pkt = make_pkt(24, 0, 0, 0, 0, 2); tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (issue_valid[2] !== 1'b1 || dut_pkt(2).dst_preg !== 6'd20) begin
                errors++;
                $display("FAIL hold_%0d: got valid=%b dst=%0d expected valid=1 dst=20", c, issue_valid[2], dut_pkt(2).dst_preg);
            end
            tick();
        end
        issue_ready[2] = 1;
        tick(); idle();
        checks++;
        if (issue_valid[2] !== 1'b1 || dut_pkt(2).dst_preg !== 6'd24) begin
            errors++;
            $display("FAIL hold_next: got valid=%b dst=%0d expected valid=1 dst=24", issue_valid[2], dut_pkt(2).dst_preg);
        end
        checks++; if (occupancy !== 6'd4) begin errors++; $display("FAIL hold_occ: got %0d expected 4", occupancy); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            disp_pkt = make_pkt(40 + i, 1, 11, 0, 0, 0); disp_valid = 1;
            tick();
        end
        idle();
        checks++; if (occupancy !== 6'd10) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 10", occupancy); end
        disp_pkt = make_pkt(50, 0, 0, 0, 0, 1); disp_valid = 1;
        flush = 1; issue_ready = 4'b1111; #1;
        checks++; if (issue_valid !== 4'b0100) begin errors++; $display("FAIL flush_cycle_valid: got %b expected 0100", issue_valid); end
        tick(); idle();
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0000", issue_valid); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", disp_ready); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            disp_pkt = make_pkt(60 + i, 0, 0, 0, 0, i); disp_valid = 1;
            tick();
        end
        disp_pkt = make_pkt(63, 0, 0, 0, 0, 3);
        rst_n = 0; #1;
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", disp_ready); end
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0000", issue_valid); end
        tick();
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
        rst_n = 1; idle(); #1;
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %b expected 1", disp_ready); end
        checks++; if (issue_valid !== 4'b0) begin errors++; $display("FAIL rstmid_release_valid: got %b expected 0000", issue_valid); end
    endtask

    task automatic test_random();
        int sel, n;
        for (int c = 0; c < 1200; c++) begin
            disp_valid = ($urandom_range(0, 9) < 7);
            disp_pkt             = make_pkt($urandom_range(0, 63), 1'($urandom), $urandom_range(0, 7),
                                            1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3));
            disp_pkt.instr_valid = ($urandom_range(0, 9) != 0);
            disp_src1_rdy        = ($urandom_range(0, 9) < 3);
            disp_src2_rdy        = ($urandom_range(0, 9) < 3);
            for (int f = 0; f < NF; f++) begin
                wb_valid[f]          = ($urandom_range(0, 9) < 2);
                wb_preg[f*PW +: PW]  = 6'($urandom_range(0, 7));
                issue_ready[f]       = ((c % 400) < 200) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 7);
            end
            flush = ($urandom_range(0, 99) < 2);
            #1;
            n = m_count();
            checks++;
            if (occupancy !== 6'(n)) begin errors++; $display("FAIL rand_occ_c%0d: got %0d expected %0d", c, occupancy, n); end
            checks++;
            if (disp_ready !== (n < RSE)) begin errors++; $display("FAIL rand_ready_c%0d: got %b expected %b", c, disp_ready, n < RSE); end
            for (int f = 0; f < NF; f++) begin
                sel = m_sel(f);
                checks++;
                if (issue_valid[f] !== (sel >= 0)) begin
                    errors++;
                    $display("FAIL rand_valid_c%0d_f%0d: got %b expected %b", c, f, issue_valid[f], sel >= 0);
                end else if (sel >= 0 && dut_pkt(f) !== m_pkt[sel]) begin
                    errors++;
                    $display("FAIL rand_pkt_c%0d_f%0d: got %h expected %h", c, f, dut_pkt(f), m_pkt[sel]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_wakeup();
        test_bypass();
        test_fill();
        test_parallel();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
